// File: rtl/regfile_2w_scoreboard.sv
// Two-read / two-write register file with post-reset clear sequencer
// and per-register pending-write scoreboard. Optional: REGFILE_BYPASS_EN.
module regfile_2w_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     ra1,
    input  logic [AW-1:0]     ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              mark_en,
    input  logic [AW-1:0]     mark_addr,
    output logic              ready
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t            state, state_n;
    logic [AW-1:0]     clr_idx, clr_idx_n;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy, busy_n;
    logic [DEPTH-1:0]  clr_vec, mark_vec;

    logic run;
    logic z_wa0, z_wa1, z_mark, z_ra1, z_ra2;
    logic wv0, wv1, mv;

    assign run    = (state == RUN);
    assign ready  = run;
    assign z_wa0  = (ZERO_REG != 0) && (wa0 == '0);
    assign z_wa1  = (ZERO_REG != 0) && (wa1 == '0);
    assign z_mark = (ZERO_REG != 0) && (mark_addr == '0);
    assign z_ra1  = (ZERO_REG != 0) && (ra1 == '0);
    assign z_ra2  = (ZERO_REG != 0) && (ra2 == '0);
    assign wv0    = run && we0 && !z_wa0;
    assign wv1    = run && we1 && !z_wa1;
    assign mv     = run && mark_en && !z_mark;

    // State and clear-index registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_n;
            clr_idx <= clr_idx_n;
        end
    end

    // Walk clr_idx over every entry, then park in RUN until reset
    always_comb begin
        state_n   = state;
        clr_idx_n = clr_idx;
        unique case (state)
            CLEAR: begin
                clr_idx_n = clr_idx + 1'b1;
                if (clr_idx == LAST) begin
                    state_n   = RUN;
                    clr_idx_n = '0;
                end
            end
            RUN: begin
                state_n = RUN;
            end
            default: begin
                state_n = CLEAR;
            end
        endcase
    end

    // Storage: zero fill while clearing, port 1 written last so it wins
    always_ff @(posedge clk) begin
        if (rst_n && !run) begin
            mem[clr_idx] <= '0;
        end else if (rst_n) begin
            if (wv0) mem[wa0] <= wd0;
            if (wv1) mem[wa1] <= wd1;
        end
    end

    // Decode this cycle's writes (clears) and marks into bit vectors
    always_comb begin
        clr_vec  = '0;
        mark_vec = '0;
        if (wv0) clr_vec[wa0] = 1'b1;
        if (wv1) clr_vec[wa1] = 1'b1;
        if (mv) mark_vec[mark_addr] = 1'b1;
        busy_n = (busy & ~clr_vec) | mark_vec;
    end

    // Scoreboard bits; a mark overrides a same-cycle clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (run) begin
            busy <= busy_n;
        end
    end

    // Combinational read ports, forced to 0 while clearing
    always_comb begin
        rd1   = '0;
        rd2   = '0;
        busy1 = 1'b0;
        busy2 = 1'b0;
        if (run && !z_ra1) begin
            rd1   = mem[ra1];
            busy1 = busy[ra1];
`ifdef REGFILE_BYPASS_EN
            if (wv0 && wa0 == ra1) rd1 = wd0;
            if (wv1 && wa1 == ra1) rd1 = wd1;
            if (clr_vec[ra1] && !mark_vec[ra1]) busy1 = 1'b0;
`endif
        end
        if (run && !z_ra2) begin
            rd2   = mem[ra2];
            busy2 = busy[ra2];
`ifdef REGFILE_BYPASS_EN
            if (wv0 && wa0 == ra2) rd2 = wd0;
            if (wv1 && wa1 == ra2) rd2 = wd1;
            if (clr_vec[ra2] && !mark_vec[ra2]) busy2 = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_2w_scoreboard.sv
// Directed scoreboard bench for regfile_2w_scoreboard.
// Expected values are queued at stimulus time and popped at sample time.
module tb_regfile_2w_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] ra1, ra2, wa0, wa1, mark_addr;
    logic [DW-1:0] rd1, rd2, wd0, wd1;
    logic          busy1, busy2, we0, we1, mark_en, ready;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } item_t;

    item_t q[$];
    int    passed = 0;
    int    total  = 0;
    int    failed = 0;
    int    n;

    regfile_2w_scoreboard dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra1       (ra1),
        .ra2       (ra2),
        .rd1       (rd1),
        .rd2       (rd2),
        .busy1     (busy1),
        .busy2     (busy2),
        .we0       (we0),
        .wa0       (wa0),
        .wd0       (wd0),
        .we1       (we1),
        .wa1       (wa1),
        .wd1       (wd1),
        .mark_en   (mark_en),
        .mark_addr (mark_addr),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        item_t it;
        it.tag = tag;
        it.exp = v;
        q.push_back(it);
    endtask

    task automatic check(input logic [31:0] obs);
        item_t it;
        if (q.size() == 0) begin
            total++;
            failed++;
            $error("FAIL queue_empty observed=%h expected=none", obs);
        end else begin
            it = q.pop_front();
            total++;
            assert (obs === it.exp) passed++;
            else begin
                failed++;
                $error("FAIL %s observed=%h expected=%h",
                       it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic idle();
        we0 = 1'b0;
        we1 = 1'b0;
        mark_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ra1 = '0; ra2 = '0;
        wa0 = '0; wa1 = '0; mark_addr = '0;
        wd0 = '0; wd1 = '0;
        idle();

        // reset then clear sequence
        step();
        step();
        expect_val("reset_ready", 32'd0);
        check({31'd0, ready});
        ra1 = 5'd5;
        #1;
        expect_val("reset_rd1", 32'd0);
        check(rd1);
        rst_n = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            if (n == 20) begin
                we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD;
                mark_en = 1'b1; mark_addr = 5'd5;
            end else begin
                idle();
            end
            step();
            n++;
        end
        idle();
        expect_val("clear_latency", 32'd32);
        check(n);
        ra1 = 5'd5; ra2 = 5'd5;
        #1;
        expect_val("clear_ignores_we", 32'd0);
        check(rd1);
        expect_val("clear_ignores_mark", 32'd0);
        check({31'd0, busy2});

        // dual write collision on address 7
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h1111;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h2222;
        ra1 = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        expect_val("collide_same_cycle", 32'h2222);
`else
        expect_val("collide_same_cycle", 32'h0);
`endif
        check(rd1);
        step();
        idle();
        ra1 = 5'd7; ra2 = 5'd7;
        #1;
        expect_val("collide_rd1", 32'h2222);
        check(rd1);
        expect_val("collide_rd2", 32'h2222);
        check(rd2);

        // independent writes on each port
        we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h1234_5678;
        we1 = 1'b1; wa1 = 5'd31; wd1 = 32'hCAFE_F00D;
        step();
        idle();
        ra1 = 5'd12; ra2 = 5'd31;
        #1;
        expect_val("port0_write", 32'h1234_5678);
        check(rd1);
        expect_val("port1_write_top", 32'hCAFE_F00D);
        check(rd2);

        // zero register drops writes and marks
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
        mark_en = 1'b1; mark_addr = 5'd0;
        step();
        idle();
        ra1 = 5'd0;
        #1;
        expect_val("zero_rd1", 32'd0);
        check(rd1);
        expect_val("zero_busy1", 32'd0);
        check({31'd0, busy1});

        // scoreboard lifecycle on address 9
        mark_en = 1'b1; mark_addr = 5'd9;
        step();
        idle();
        step();
        step();
        step();
        ra2 = 5'd9; ra1 = 5'd8;
        #1;
        expect_val("sb_busy_set", 32'd1);
        check({31'd0, busy2});
        expect_val("sb_neighbour", 32'd0);
        check({31'd0, busy1});
        mark_en = 1'b1; mark_addr = 5'd9;
        step();
        idle();
        #1;
        expect_val("sb_remark", 32'd1);
        check({31'd0, busy2});
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h0000_ABCD;
        step();
        idle();
        #1;
        expect_val("sb_cleared", 32'd0);
        check({31'd0, busy2});
        expect_val("sb_data", 32'h0000_ABCD);
        check(rd2);

        // mark and write race on address 4
        mark_en = 1'b1; mark_addr = 5'd4;
        we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h4444;
        step();
        idle();
        ra1 = 5'd4;
        #1;
        expect_val("race_busy", 32'd1);
        check({31'd0, busy1});
        expect_val("race_data", 32'h4444);
        check(rd1);

        // reset in the middle of clearing
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        expect_val("midclear_latency", 32'd32);
        check(n);
        ra1 = 5'd4; ra2 = 5'd9;
        #1;
        expect_val("midclear_busy1", 32'd0);
        check({31'd0, busy1});
        expect_val("midclear_busy2", 32'd0);
        check({31'd0, busy2});
        ra1 = 5'd7; ra2 = 5'd31;
        #1;
        expect_val("midclear_rd1", 32'd0);
        check(rd1);
        expect_val("midclear_rd2", 32'd0);
        check(rd2);

        if (q.size() != 0) begin
            total++;
            failed++;
            $error("FAIL queue_leftover observed=%0d expected=0", q.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
